// File: rtl/mips_dmem.sv
// Data-memory responder for the pipelined MIPS core: byte-lane RAM, 1-cycle loads, unmapped-access counter.
// Build option DMEM_MMIO_EN adds the 4'hF MMIO block (CYCLE, CMP, STATUS.MATCH, SCRATCH).
module mips_dmem #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] OOR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  mem_write_en,
    input  logic        mem_read_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic [7:0]  oor_count
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] word_idx;
    logic [3:0]        region;
    logic              access;
    logic              rd_req;
    logic              sel_ram;
    logic              sel_mmio;
    logic              sel_oor;
    logic [31:0]       ram_q;
    logic [31:0]       other_q_reg;
    logic              src_ram_reg;
    logic [31:0]       other_next;
    logic [7:0]        oor_count_reg;

    assign word_idx = mem_addr[ADDR_W+1:2];
    assign region   = mem_addr[31:28];
    assign access   = en && (mem_read_en || (|mem_write_en));
    assign rd_req   = en && mem_read_en;
    assign sel_ram  = (region == 4'h0);
    assign sel_oor  = !sel_ram && !sel_mmio;

    // One 8-bit array per lane so each lane infers its own byte-wide RAM with a registered read.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst && en && sel_ram && mem_write_en[gi])
                    lane_mem[word_idx] <= mem_write_data[gi*8 +: 8];
                if (rd_req && sel_ram)
                    ram_q[gi*8 +: 8] <= lane_mem[word_idx];
            end
        end
    endgenerate

`ifdef DMEM_MMIO_EN
    logic [31:0] cycle_reg;
    logic [31:0] cmp_reg;
    logic [31:0] cmp_next;
    logic [31:0] scratch_reg;
    logic [31:0] scratch_next;
    logic        match_reg;
    logic        match_set;
    logic        match_clr;
    logic [1:0]  mmio_off;
    logic        mmio_wr;
    logic [31:0] mmio_rdata;

    assign sel_mmio  = (region == 4'hF);
    assign mmio_off  = mem_addr[3:2];
    assign mmio_wr   = sel_mmio && (|mem_write_en);
    // Compare uses the registered CMP, so a same-cycle CMP write does not affect this cycle's match.
    assign match_set = (cmp_reg != 32'd0) && (cycle_reg == cmp_reg);
    assign match_clr = sel_mmio && (mmio_off == 2'd2) && mem_write_en[0] && mem_write_data[0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mmio_lane
            assign cmp_next[gi*8 +: 8] = (mmio_wr && mmio_off == 2'd1 && mem_write_en[gi])
                                         ? mem_write_data[gi*8 +: 8] : cmp_reg[gi*8 +: 8];
            assign scratch_next[gi*8 +: 8] = (mmio_wr && mmio_off == 2'd3 && mem_write_en[gi])
                                             ? mem_write_data[gi*8 +: 8] : scratch_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        mmio_rdata = 32'd0;
        case (mmio_off)
            2'd0:    mmio_rdata = cycle_reg;
            2'd1:    mmio_rdata = cmp_reg;
            2'd2:    mmio_rdata = {31'd0, match_reg};
            default: mmio_rdata = scratch_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_reg   <= 32'd0;
            cmp_reg     <= 32'd0;
            scratch_reg <= 32'd0;
            match_reg   <= 1'b0;
        end else if (en) begin
            cycle_reg   <= cycle_reg + 32'd1;
            cmp_reg     <= cmp_next;
            scratch_reg <= scratch_next;
            match_reg   <= match_set || (match_reg && !match_clr);
        end
    end

    assign other_next = sel_mmio ? mmio_rdata : OOR_DATA;
`else
    assign sel_mmio   = 1'b0;
    assign other_next = OOR_DATA;
`endif

    // RAM loads come from the lane RAM outputs; everything else from other_q_reg (reset to 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            src_ram_reg <= 1'b0;
            other_q_reg <= 32'd0;
        end else if (rd_req) begin
            src_ram_reg <= sel_ram;
            if (!sel_ram)
                other_q_reg <= other_next;
        end
    end

    assign mem_read_data = src_ram_reg ? ram_q : other_q_reg;

    always_ff @(posedge clk) begin
        if (rst)
            oor_count_reg <= 8'd0;
        else if (access && sel_oor && oor_count_reg != 8'hFF)
            oor_count_reg <= oor_count_reg + 8'd1;
    end

    assign oor_count = oor_count_reg;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[27:ADDR_W+2], mem_addr[1:0]};
endmodule
